// File: rtl/keypad_press_encoder.sv
// keypad_press_encoder: turns 4 raw push-buttons into one-hot key pulses.
// Sync, debounce, multi-press reject, one pulse per physical press.
//
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   button   : raw async buttons, bit3 -> key 4'b1000 ... bit0 -> 4'b0001
//   key      : one-hot key code, 4'b0000 when idle
//   busy     : high whenever the FSM is not in IDLE
//   rejected : one-cycle pulse when a multi-button press is dropped
//   pressed  : debounced pressed state, active-high
module keypad_press_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned PULSE_CYCLES      = 4,
  parameter int unsigned GAP_CYCLES        = 2,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] button,
  output logic [3:0] key,
  output logic       busy,
  output logic       rejected,
  output logic [3:0] pressed
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned T_MAX =
    (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned T_W = $clog2(T_MAX + 1);

  localparam logic [DB_W-1:0] DB_END = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [T_W-1:0]  P_LOAD = T_W'(PULSE_CYCLES - 1);
  localparam logic [T_W-1:0]  G_LOAD = T_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    WAIT_RELEASE
  } state_t;

  logic [3:0]            btn_norm;
  logic [3:0]            sync1;
  logic [3:0]            sync2;
  logic [3:0][DB_W-1:0]  db_cnt;
  logic [3:0]            pressed_d;
  logic [3:0]            new_press;
  logic                  multi;
  logic [1:0]            settle;
  logic                  armed;

  state_t                state_q, state_d;
  logic [3:0]            key_q, key_d;
  logic                  rej_q, rej_d;
  logic [T_W-1:0]        tcnt_q, tcnt_d;

  assign btn_norm = BUTTON_ACTIVE_LOW ? ~button : button;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_norm;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt    <= '0;
      pressed   <= '0;
      pressed_d <= '0;
    end else begin
      pressed_d <= pressed;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_END) begin
          pressed[i] <= sync2[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A button still held across reset must not produce a pulse once it
  // re-debounces; acceptance is armed only after the synchroniser has
  // refilled and everything reads released.
  always_ff @(posedge clock) begin
    if (reset) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd2) begin
        settle <= settle + 1'b1;
      end
      if (settle == 2'd2 && sync2 == 4'b0 && pressed == 4'b0) begin
        armed <= 1'b1;
      end
    end
  end

  assign new_press = pressed & ~pressed_d;
  assign multi     = (new_press & (new_press - 4'd1)) != 4'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      rej_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rej_q   <= rej_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rej_d   = 1'b0;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (armed && new_press != 4'b0) begin
          if (multi) begin
            state_d = WAIT_RELEASE;
            rej_d   = 1'b1;
          end else begin
            state_d = PULSE;
            key_d   = new_press;
            tcnt_d  = P_LOAD;
          end
        end
      end
      PULSE: begin
        if (tcnt_q == '0) begin
          state_d = GAP;
          key_d   = 4'b0;
          tcnt_d  = G_LOAD;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      GAP: begin
        if (tcnt_q == '0) begin
          state_d = WAIT_RELEASE;
        end else begin
          tcnt_d = tcnt_q - 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (pressed == 4'b0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        key_d   = 4'b0;
      end
    endcase
  end

  assign key      = key_q;
  assign rejected = rej_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_press_encoder.sv
// tb_keypad_press_encoder: directed bench for keypad_press_encoder.
// Debounce 4, pulse 2, gap 2, active-low buttons.
module tb_keypad_press_encoder;

  logic       clock;
  logic       reset;
  logic [3:0] button;
  logic [3:0] key;
  logic       busy;
  logic       rejected;
  logic [3:0] pressed;

  int total;
  int bad;

  logic       mon_en;
  logic [3:0] prev_key;
  int         plen;
  int         zero_run;
  int         min_gap;
  bit         seen_pulse;
  int         rej_cycles;
  logic [3:0] pressed_or;
  logic [3:0] pulse_keys[$];
  int         pulse_lens[$];

  keypad_press_encoder #(
    .DEBOUNCE_CYCLES  (4),
    .PULSE_CYCLES     (2),
    .GAP_CYCLES       (2),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .button  (button),
    .key     (key),
    .busy    (busy),
    .rejected(rejected),
    .pressed (pressed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    pulse_keys.delete();
    pulse_lens.delete();
    rej_cycles = 0;
    pressed_or = 4'b0;
    min_gap    = 1000;
    seen_pulse = 1'b0;
    zero_run   = 0;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      check("onehot", {31'b0, $onehot0(key)}, 32'd1);
      check("rej_key", {31'b0, (rejected && key != 4'b0)}, 32'd0);
      if (rejected) rej_cycles++;
      pressed_or = pressed_or | pressed;
      if (key != 4'b0) begin
        if (prev_key == 4'b0) begin
          pulse_keys.push_back(key);
          plen = 0;
          if (seen_pulse && zero_run < min_gap) min_gap = zero_run;
          seen_pulse = 1'b1;
        end else begin
          check("key_stable", {28'b0, key}, {28'b0, prev_key});
        end
        plen++;
        zero_run = 0;
      end else begin
        if (prev_key != 4'b0) pulse_lens.push_back(plen);
        zero_run++;
      end
      prev_key = key;
    end
  end

  function automatic logic [31:0] qkey(input int i);
    return (pulse_keys.size() > i) ? {28'b0, pulse_keys[i]} : 32'hdead;
  endfunction

  function automatic logic [31:0] qlen(input int i);
    return (pulse_lens.size() > i) ? pulse_lens[i] : 32'hdead;
  endfunction

  logic [3:0] seq_btn[4];
  logic [3:0] seq_key[4];
  bit         got_key;

  initial begin
    total    = 0;
    bad      = 0;
    mon_en   = 1'b0;
    prev_key = 4'b0;
    plen     = 0;
    clear_log();

    // reset with button 3 held
    reset  = 1'b1;
    button = 4'b0111;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_key", {28'b0, key}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_pressed", {28'b0, pressed}, 32'd0);
    end
    reset  = 1'b0;
    button = 4'b1111;
    mon_en = 1'b1;
    ticks(10);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // single press of button 3
    clear_log();
    button = 4'b0111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 6) check("s_pressed_lo", {28'b0, pressed}, 32'h0);
      if (k == 7) check("s_pressed_hi", {28'b0, pressed}, 32'h8);
      if (k == 7) check("s_key_pre", {28'b0, key}, 32'h0);
      if (k == 8) check("s_key_a", {28'b0, key}, 32'h8);
      if (k == 9) check("s_key_b", {28'b0, key}, 32'h8);
      if (k == 10) check("s_key_end", {28'b0, key}, 32'h0);
      if (k == 12) check("s_busy_hold", {31'b0, busy}, 32'd1);
    end
    button = 4'b1111;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 5) check("s_busy_rel", {31'b0, busy}, 32'd1);
      if (j == 9) check("s_busy_done", {31'b0, busy}, 32'd0);
    end
    check("s_npulse", pulse_keys.size(), 32'd1);
    check("s_len", qlen(0), 32'd2);

    // bounce on button 2
    clear_log();
    for (int c = 0; c < 3; c++) begin
      button = 4'b1011;
      ticks(2);
      button = 4'b1111;
      ticks(2);
    end
    ticks(15);
    check("b_pressed", {28'b0, pressed_or}, 32'h0);
    check("b_npulse", pulse_keys.size(), 32'd0);

    // multi-press rejected, then single press of button 0
    clear_log();
    button = 4'b1100;
    ticks(15);
    check("m_rej", rej_cycles, 32'd1);
    check("m_npulse", pulse_keys.size(), 32'd0);
    check("m_pressed", {28'b0, pressed}, 32'h3);
    check("m_busy", {31'b0, busy}, 32'd1);
    button = 4'b1111;
    ticks(15);
    check("m_idle", {31'b0, busy}, 32'd0);
    button = 4'b1110;
    ticks(15);
    check("m_npulse2", pulse_keys.size(), 32'd1);
    check("m_key", qkey(0), 32'h1);
    check("m_len", qlen(0), 32'd2);
    button = 4'b1111;
    ticks(15);

    // lock code 8,4,8,1
    clear_log();
    seq_btn = '{4'b0111, 4'b1011, 4'b0111, 4'b1110};
    seq_key = '{4'b1000, 4'b0100, 4'b1000, 4'b0001};
    for (int s = 0; s < 4; s++) begin
      button = seq_btn[s];
      ticks(12);
      button = 4'b1111;
      ticks(12);
    end
    check("l_npulse", pulse_keys.size(), 32'd4);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("l_key%0d", s), qkey(s), {28'b0, seq_key[s]});
      check($sformatf("l_len%0d", s), qlen(s), 32'd2);
    end
    check("l_gap", {31'b0, (min_gap >= 2)}, 32'd1);

    // reset on first pulse cycle
    clear_log();
    button  = 4'b0111;
    got_key = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (key != 4'b0) begin
        got_key = 1'b1;
        break;
      end
    end
    check("r_key_up", {31'b0, got_key}, 32'd1);
    reset = 1'b1;
    tick();
    check("r_key", {28'b0, key}, 32'h0);
    check("r_busy", {31'b0, busy}, 32'd0);
    check("r_pressed", {28'b0, pressed}, 32'h0);
    reset = 1'b0;
    clear_log();
    ticks(30);
    check("r_nopulse", pulse_keys.size(), 32'd0);
    check("r_held_busy", {31'b0, busy}, 32'd0);
    button = 4'b1111;
    ticks(15);
    button = 4'b0111;
    ticks(12);
    check("r_npulse", pulse_keys.size(), 32'd1);
    check("r_key2", qkey(0), 32'h8);
    button = 4'b1111;
    ticks(15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
